// File: rtl/object_shifter_pkg.sv
// Shared constants for the object shifter playfield: segment width, position count,
// blank pattern and the active-low shape table indexed by the RNG value.
package object_shifter_pkg;

    localparam int SEG_W   = 7;
    localparam int NUM_POS = 6;

    localparam logic [SEG_W-1:0] BLANK = 7'b1111111;

    // Entry 7 is the leftmost element, entry 0 the rightmost; bit order {g,f,e,d,c,b,a}.
    localparam logic [7:0][SEG_W-1:0] SHAPE_TABLE = {
        7'b0100011,
        7'b0011100,
        7'b1110110,
        7'b0110111,
        7'b0111110,
        7'b1110111,
        7'b0111111,
        7'b1111110
    };

endpackage

// File: rtl/object_shape_decoder.sv
// Combinational lookup from the 3-bit random selector to a 7-segment shape.
module object_shape_decoder
    import object_shifter_pkg::*;
(
    input  logic [2:0]       rng_read_in,
    output logic [SEG_W-1:0] shape
);

    // Table lookup; all 8 selector values are populated.
    always_comb begin
        shape = SHAPE_TABLE[rng_read_in];
    end

endmodule

// File: rtl/object_shifter.sv
// Six-position 7-segment playfield that scrolls shapes/blanks from Out5 towards Out0.
// Optional OBJECT_SHIFTER_DODGE_EN enables the DebrisDodge exit pulse.
module object_shifter
    import object_shifter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             ShiftPulse,
    input  logic             ObjShifterEnable,
    input  logic             Reconfig,
    input  logic [2:0]       RNGReadIn,
    output logic [SEG_W-1:0] Out5,
    output logic [SEG_W-1:0] Out4,
    output logic [SEG_W-1:0] Out3,
    output logic [SEG_W-1:0] Out2,
    output logic [SEG_W-1:0] Out1,
    output logic [SEG_W-1:0] Out0,
    output logic             DebrisDodge
);

    logic [SEG_W-1:0] pos_r [NUM_POS];
    logic             phase_r;
    logic [SEG_W-1:0] shape_s;
    logic             shift_s;

    object_shape_decoder u_decoder (
        .rng_read_in (RNGReadIn),
        .shape       (shape_s)
    );

    assign shift_s = ObjShifterEnable & ShiftPulse;

    // Playfield and phase register; reset and Reconfig both return to blank with phase 1.
    always_ff @(posedge clk) begin
        if (!rst || Reconfig) begin
            for (int i = 0; i < NUM_POS; i++) begin
                pos_r[i] <= BLANK;
            end
            phase_r <= 1'b1;
        end else if (shift_s) begin
            for (int i = 0; i < NUM_POS-1; i++) begin
                pos_r[i] <= pos_r[i+1];
            end
            pos_r[NUM_POS-1] <= phase_r ? shape_s : BLANK;
            phase_r          <= ~phase_r;
        end else begin
            for (int i = 0; i < NUM_POS; i++) begin
                pos_r[i] <= pos_r[i];
            end
            phase_r <= phase_r;
        end
    end

`ifdef OBJECT_SHIFTER_DODGE_EN
    logic dodge_r;

    // One-cycle pulse when a non-blank pattern is pushed out of the exit position.
    always_ff @(posedge clk) begin
        if (!rst || Reconfig) begin
            dodge_r <= 1'b0;
        end else if (shift_s) begin
            dodge_r <= (pos_r[0] != BLANK);
        end else begin
            dodge_r <= 1'b0;
        end
    end

    assign DebrisDodge = dodge_r;
`else
    assign DebrisDodge = 1'b0;
`endif

    assign Out5 = pos_r[5];
    assign Out4 = pos_r[4];
    assign Out3 = pos_r[3];
    assign Out2 = pos_r[2];
    assign Out1 = pos_r[1];
    assign Out0 = pos_r[0];

endmodule

// File: tb/tb_object_shifter.sv
// Scoreboard bench for object_shifter: a reference model pushes the expected
// playfield each cycle, and each scenario task pops and compares after the edge.
module tb_object_shifter;

    localparam logic [6:0] BLK = 7'b1111111;
`ifdef OBJECT_SHIFTER_DODGE_EN
    localparam logic DODGE_EN = 1'b1;
`else
    localparam logic DODGE_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ShiftPulse = 1'b0;
    logic       ObjShifterEnable = 1'b0;
    logic       Reconfig = 1'b0;
    logic [2:0] RNGReadIn = 3'd0;
    logic [6:0] Out5, Out4, Out3, Out2, Out1, Out0;
    logic       DebrisDodge;

    logic [42:0] obs;
    logic [42:0] exp_v;
    logic [42:0] sb [$];
    logic [6:0]  m_pos [6];
    logic        m_phase;
    logic        m_dodge;
    int          n_cmp = 0;
    int          n_fail = 0;

    object_shifter dut (
        .clk              (clk),
        .rst              (rst),
        .ShiftPulse       (ShiftPulse),
        .ObjShifterEnable (ObjShifterEnable),
        .Reconfig         (Reconfig),
        .RNGReadIn        (RNGReadIn),
        .Out5             (Out5),
        .Out4             (Out4),
        .Out3             (Out3),
        .Out2             (Out2),
        .Out1             (Out1),
        .Out0             (Out0),
        .DebrisDodge      (DebrisDodge)
    );

    always #5 clk = ~clk;

    assign obs = {Out5, Out4, Out3, Out2, Out1, Out0, DebrisDodge};

    function automatic logic [6:0] ref_shape(input logic [2:0] sel);
        case (sel)
            3'd0:    return 7'b1111110;
            3'd1:    return 7'b0111111;
            3'd2:    return 7'b1110111;
            3'd3:    return 7'b0111110;
            3'd4:    return 7'b0110111;
            3'd5:    return 7'b1110110;
            3'd6:    return 7'b0011100;
            3'd7:    return 7'b0100011;
            default: return 7'bxxxxxxx;
        endcase
    endfunction

    // Drive one cycle of inputs, advance the reference model, push the expectation.
    task automatic cycle(input logic r, input logic rc, input logic en, input logic sp,
                         input logic [2:0] rng);
        @(negedge clk);
        rst = r; Reconfig = rc; ObjShifterEnable = en; ShiftPulse = sp; RNGReadIn = rng;
        if (!r || rc) begin
            for (int i = 0; i < 6; i++) m_pos[i] = BLK;
            m_phase = 1'b1;
            m_dodge = 1'b0;
        end else if (en && sp) begin
            m_dodge = DODGE_EN && (m_pos[0] != BLK);
            for (int i = 0; i < 5; i++) m_pos[i] = m_pos[i+1];
            m_pos[5] = m_phase ? ref_shape(rng) : BLK;
            m_phase  = ~m_phase;
        end else begin
            m_dodge = 1'b0;
        end
        sb.push_back({m_pos[5], m_pos[4], m_pos[3], m_pos[2], m_pos[1], m_pos[0], m_dodge});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'($urandom_range(1, 0)), 1'b1, 1'b1, 3'($urandom_range(7, 0)));
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL reset_sb: got %h want %h", obs, exp_v); end
        end
        n_cmp++;
        if (obs !== {{6{BLK}}, 1'b0}) begin n_fail++; $display("FAIL reset_blank: got %h want %h", obs, {{6{BLK}}, 1'b0}); end
    endtask

    task automatic test_alternation;
        logic [2:0] rs [4];
        logic [6:0] o5 [4];
        rs = '{3'd3, 3'd5, 3'd0, 3'd6};
        o5 = '{7'b0111110, 7'b1111111, 7'b1111110, 7'b1111111};
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 1'b0, 1'b1, 1'b1, rs[k]);
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL alt_sb: got %h want %h", obs, exp_v); end
            n_cmp++;
            if (Out5 !== o5[k]) begin n_fail++; $display("FAIL alt_out5[%0d]: got %b want %b", k, Out5, o5[k]); end
            cycle(1'b1, 1'b0, 1'b1, 1'b0, 3'd2);
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL alt_idle: got %h want %h", obs, exp_v); end
        end
        n_cmp++;
        if (Out4 !== 7'b1111110) begin n_fail++; $display("FAIL alt_out4: got %b want 1111110", Out4); end
        n_cmp++;
        if (Out2 !== 7'b0111110) begin n_fail++; $display("FAIL alt_out2: got %b want 0111110", Out2); end
    endtask

    task automatic test_exit;
        logic want_dd;
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 1'b0, 1'b1, 1'b1, 3'(k));
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL exit_sb: got %h want %h", obs, exp_v); end
            want_dd = (k == 2) ? DODGE_EN : 1'b0;
            n_cmp++;
            if (DebrisDodge !== want_dd) begin n_fail++; $display("FAIL exit_dodge[%0d]: got %b want %b", k, DebrisDodge, want_dd); end
            if (k == 1) begin
                n_cmp++;
                if (Out0 !== 7'b0111110) begin n_fail++; $display("FAIL exit_out0: got %b want 0111110", Out0); end
            end
            cycle(1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs !== exp_v || DebrisDodge !== 1'b0) begin n_fail++; $display("FAIL exit_idle: got %h want %h", obs, exp_v); end
        end
    endtask

    task automatic test_back_to_back;
        for (int k = 0; k < 6; k++) begin
            cycle(1'b1, 1'b0, 1'b1, 1'b1, 3'(7 - k));
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL b2b_sb[%0d]: got %h want %h", k, obs, exp_v); end
        end
    endtask

    task automatic test_disable;
        logic [42:0] held;
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
        held = sb.pop_front();
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 1'b0, 1'b0, (k % 2 == 0), 3'd1);
            exp_v = sb.pop_front();
            n_cmp++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL dis_sb: got %h want %h", obs, exp_v); end
            n_cmp++;
            if (obs[42:1] !== held[42:1] || DebrisDodge !== 1'b0) begin n_fail++; $display("FAIL dis_hold: got %h want %h", obs, {held[42:1], 1'b0}); end
        end
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 3'd5);
        exp_v = sb.pop_front();
        n_cmp++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL dis_phase: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_reconfig;
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 3'd4);
        exp_v = sb.pop_front();
        n_cmp++;
        if (obs !== {{6{BLK}}, 1'b0}) begin n_fail++; $display("FAIL reconfig_blank: got %h want %h", obs, {{6{BLK}}, 1'b0}); end
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 3'd7);
        exp_v = sb.pop_front();
        n_cmp++;
        if (obs !== exp_v || Out5 !== 7'b0100011) begin n_fail++; $display("FAIL reconfig_first: got %h want %h", obs, exp_v); end
    endtask

    task automatic test_reset_mid;
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 3'd6);
        void'(sb.pop_front());
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 3'd6);
        void'(sb.pop_front());
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 3'd4);
        exp_v = sb.pop_front();
        n_cmp++;
        if (obs !== {7'b0110111, {5{BLK}}, 1'b0} || obs !== exp_v) begin
            n_fail++; $display("FAIL reset_mid: got %h want %h", obs, {7'b0110111, {5{BLK}}, 1'b0});
        end
    endtask

    task automatic test_lfsr;
        logic [2:0] lfsr;
        logic       hit;
        lfsr = 3'b101;
        cycle(1'b1, 1'b1, 1'b1, 1'b0, lfsr);
        void'(sb.pop_front());
        for (int p = 0; p < 14; p++) begin
            for (int c = 0; c < 13; c++) begin
                lfsr = {lfsr[1:0], lfsr[2] ^ lfsr[1]};
                cycle(1'b1, 1'b0, 1'b1, (c == 0), lfsr);
                exp_v = sb.pop_front();
                n_cmp++;
                if (obs !== exp_v) begin n_fail++; $display("FAIL lfsr_sb[%0d,%0d]: got %h want %h", p, c, obs, exp_v); end
                if (c == 0) begin
                    hit = 1'b0;
                    for (int s = 0; s < 8; s++) if (Out5 === ref_shape(3'(s))) hit = 1'b1;
                    n_cmp++;
                    if ((p % 2 == 0) ? !hit : (Out5 !== BLK)) begin
                        n_fail++; $display("FAIL lfsr_alt[%0d]: got %b want %s", p, Out5, (p % 2 == 0) ? "shape" : "blank");
                    end
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 6; i++) m_pos[i] = BLK;
        m_phase = 1'b1;
        m_dodge = 1'b0;
        test_reset;
        test_alternation;
        test_exit;
        test_back_to_back;
        test_disable;
        test_reconfig;
        test_reset_mid;
        test_lfsr;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/object_shifter.md
OBJECT_SHIFTER -- requirements
Module: object_shifter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Port `clk`: input, 1 bit, system clock; all state updates on its rising edge.
REQ-003 Port `rst`: input, 1 bit, synchronous active-low reset.
REQ-004 Port `ShiftPulse`: input, 1 bit, shift request, sampled each rising edge.
REQ-005 Port `ObjShifterEnable`: input, 1 bit, gates shifting; low means freeze.
REQ-006 Port `Reconfig`: input, 1 bit, synchronous clear of the playfield and phase.
REQ-007 Port `RNGReadIn`: input, 3 bits, random shape selector from an external 3-bit LFSR.
REQ-008 Ports `Out5` through `Out0`: outputs, 7 bits each, active-low 7-segment patterns, bit order {g,f,e,d,c,b,a}; `Out5` is the entry position and `Out0` the exit position.
REQ-009 Port `DebrisDodge`: output, 1 bit, one-cycle pulse when debris leaves `Out0`.

Function
REQ-010 Blank SHALL be 7'b1111111.
REQ-011 The shape table SHALL map `RNGReadIn` values as follows:
- 0 -> 1111110 (a)
- 1 -> 0111111 (g)
- 2 -> 1110111 (d)
- 3 -> 0111110 (a+g)
- 4 -> 0110111 (g+d)
- 5 -> 1110110 (a+d)
- 6 -> 0011100 (a,b,f,g)
- 7 -> 0100011 (c,d,e,g)
REQ-012 A shift occurs on a rising edge where `rst`=1, `Reconfig`=0, `ObjShifterEnable`=1 and `ShiftPulse`=1.
REQ-013 On a shift:
- Out0 <= Out1, Out1 <= Out2, Out2 <= Out3, Out3 <= Out4, Out4 <= Out5.
- The old Out0 is discarded.
REQ-014 On a shift, the new Out5 SHALL be the decoded `RNGReadIn` sampled at that edge if phase=1, else blank.
REQ-015 Phase is a 1-bit register that toggles on every shift, so shape, blank, shape, ... alternate.
REQ-016 Outputs SHALL update at the same edge that samples `ShiftPulse`, giving one-cycle latency.
REQ-017 `ShiftPulse` held high for N cycles SHALL produce N shifts; it is level-sampled with no edge detection.
REQ-018 With `ObjShifterEnable`=0, all outputs and phase SHALL hold and `ShiftPulse` is ignored.
REQ-019 `DebrisDodge` SHALL be registered high for exactly the cycle after a shift whose pre-shift Out0 was non-blank; it is low otherwise.
REQ-020 `Reconfig`=1 (with `rst`=1) SHALL, at the edge:
- set all outputs to blank;
- set phase to 1;
- clear `DebrisDodge`;
- override any shift in the same cycle.
REQ-021 Priority SHALL be: reset > `Reconfig` > shift > hold.

Reset
REQ-022 `rst`=0 at a rising edge SHALL set Out5..Out0 to blank, phase to 1 and `DebrisDodge` to 0, regardless of other inputs.
REQ-023 Reset asserted mid-sequence SHALL discard the playfield completely; the first shift after reset inserts a shape.

Configuration
REQ-024 Macro `OBJECT_SHIFTER_DODGE_EN`:
- Defined: `DebrisDodge` behaves per REQ-019.
- Undefined: `DebrisDodge` is constant 0, its register is omitted, and the port remains.

Structure
REQ-025 Package `object_shifter_pkg` SHALL hold:
- segment width (7);
- number of positions (6);
- the blank constant;
- the 8-entry shape table.
REQ-026 Sub-module `object_shape_decoder` SHALL be purely combinational, mapping 3-bit `RNGReadIn` to a 7-bit pattern via the package table.

Verification
REQ-027 Reset: hold `rst`=0 for 3 cycles -> all Out = 1111111, `DebrisDodge`=0.
REQ-028 Alternation: enable, then four single-cycle shifts with `RNGReadIn`=3, 5, 0, 6:
- Out5 after each shift = 0111110, 1111111, 1111110, 1111111.
- After the 4th shift, Out4 = 1111110, Out2 = 0111110.
REQ-029 Exit: continue shifting until the first shape reaches Out0, then shift once more -> `DebrisDodge`=1 for exactly one cycle; a blank leaving Out0 -> no pulse.
REQ-030 Disable: `ObjShifterEnable`=0, then two `ShiftPulse` pulses -> outputs and phase unchanged, `DebrisDodge`=0.
REQ-031 `Reconfig` and `ShiftPulse` high in the same cycle -> all blank, next shift inserts a shape.
REQ-032 Free-running 3-bit LFSR on `RNGReadIn`, 14 pulses spaced 13 cycles apart -> alternating pattern throughout, every inserted shape among the 8 table entries.
